// File: rtl/mul_div_if.sv
// Issue/writeback bundle between decode, the multiply/divide unit and the register bank.
// Vectors are big-endian (bit 0 = MSB) to match the datapath.
`timescale 1ns/1ps
interface mul_div_if;
    logic        start;
    logic [0:1]  op;
    logic [0:15] opA;
    logic [0:15] opB;
    logic [0:3]  dstAddr;
    logic        busy;
    logic        write;
    logic [0:3]  wrAddr;
    logic [0:15] wrData;

    modport master (
        output start, op, opA, opB, dstAddr,
        input  busy, write, wrAddr, wrData
    );

    modport slave (
        input  start, op, opA, opB, dstAddr,
        output busy, write, wrAddr, wrData
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle unsigned 16-bit multiply (shift-add) / divide (restoring) unit with a
// fixed 17-cycle start-to-writeback latency and a single-cycle register-bank write strobe.
`timescale 1ns/1ps
module mul_div_unit (
    input  logic      clk,
    input  logic      rst,
    mul_div_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic [1:0] OP_MULLO = 2'b00;
    localparam logic [1:0] OP_MULHI = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    logic [1:0]  state_r;
    logic [1:0]  op_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [3:0]  dst_r;
    logic [31:0] acc_r;
    logic [15:0] quo_r;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic        write_r;
    logic [3:0]  wr_addr_r;
    logic [15:0] wr_data_r;

    logic [3:0]  bit_idx_s;
    logic [31:0] mul_next_s;
    logic [16:0] shifted_s;
    logic [16:0] divisor_s;
    logic        fits_s;
    logic [16:0] rem_next_s;
    logic [15:0] quo_next_s;
    logic [31:0] acc_next_s;
    logic [15:0] result_s;

    // One multiply or divide iteration; both walk the operand bits MSB first.
    always_comb begin
        bit_idx_s  = 4'd15 - cnt_r;
        mul_next_s = {acc_r[30:0], 1'b0} + (b_r[bit_idx_s] ? {16'd0, a_r} : 32'd0);
        shifted_s  = {acc_r[15:0], a_r[bit_idx_s]};
        divisor_s  = {1'b0, b_r};
        fits_s     = (shifted_s >= divisor_s);
        if (fits_s) begin
            rem_next_s = shifted_s - divisor_s;
        end else begin
            rem_next_s = shifted_s;
        end
        quo_next_s = {quo_r[14:0], fits_s};
        if (op_r[1]) begin
            acc_next_s = {15'd0, rem_next_s};
        end else begin
            acc_next_s = mul_next_s;
        end
    end

    // Result selection uses the post-iteration values so the last step can be written directly.
    always_comb begin
        case (op_r)
            OP_MULLO: result_s = mul_next_s[15:0];
            OP_MULHI: result_s = mul_next_s[31:16];
            OP_DIVU:  result_s = quo_next_s;
            OP_REMU:  result_s = rem_next_s[15:0];
            default:  result_s = 16'd0;
        endcase
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            op_r      <= 2'd0;
            a_r       <= 16'd0;
            b_r       <= 16'd0;
            dst_r     <= 4'd0;
            acc_r     <= 32'd0;
            quo_r     <= 16'd0;
            cnt_r     <= 4'd0;
            busy_r    <= 1'b0;
            write_r   <= 1'b0;
            wr_addr_r <= 4'd0;
            wr_data_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    write_r <= 1'b0;
                    if (bus.start) begin
                        op_r    <= bus.op;
                        a_r     <= bus.opA;
                        b_r     <= bus.opB;
                        dst_r   <= bus.dstAddr;
                        acc_r   <= 32'd0;
                        quo_r   <= 16'd0;
                        cnt_r   <= 4'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == 4'd15) begin
                        state_r   <= ST_WRITE;
                        write_r   <= 1'b1;
                        wr_addr_r <= dst_r;
                        wr_data_r <= result_s;
                    end else begin
                        state_r   <= ST_RUN;
                    end
                end
                ST_WRITE: begin
                    write_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    write_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.write  = write_r;
    assign bus.wrAddr = wr_addr_r;
    assign bus.wrData = wr_data_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit: results, latency, ignored starts,
// back-to-back issue and asynchronous reset mid-operation.
`timescale 1ns/1ps
module tb_mul_div_unit;
    logic clk;
    logic rst;
    mul_div_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   wr_pulses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts write strobes as the register bank would capture them.
    always @(posedge clk) begin
        if (bus.write === 1'b1) wr_pulses <= wr_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] dst);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.opA     = a;
        bus.opB     = b;
        bus.dstAddr = dst;
    endtask

    // Waits (bounded) for the write strobe, k negedges from the caller's reference point.
    task automatic wait_write(input int exp_k, input bit stress, input bit drop_start);
        int   k = 0;
        bit   seen = 1'b0;
        bit   busy_ok = 1'b1;
        exp_t e;
        while (!seen && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1 && drop_start) begin
                bus.start   = 1'b0;
                bus.op      = 2'($urandom);
                bus.opA     = 16'($urandom);
                bus.opB     = 16'($urandom);
                bus.dstAddr = 4'($urandom);
            end
            if (stress && k == 5) drive(2'b00, 16'hFFFF, 16'h0003, 4'hC);
            if (stress && k == 6) bus.start = 1'b0;
            if (stress && k == 17) drive(2'b01, 16'h7777, 16'h5555, 4'hD);
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.write === 1'b1) seen = 1'b1;
        end
        check("latency", k, exp_k);
        check("busy_during_op", busy_ok, 1'b1);
        check("sb_nonempty", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("wrAddr", bus.wrAddr, e.addr);
            check("wrData", bus.wrData, e.data);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] dst, input logic [15:0] exp, input bit stress);
        int p0;
        @(negedge clk);
        drive(op, a, b, dst);
        sb_q.push_back('{addr: dst, data: exp});
        p0 = wr_pulses;
        wait_write(17, stress, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        check("write_dropped", bus.write, 1'b0);
        check("busy_dropped", bus.busy, 1'b0);
        check("wrAddr_hold", bus.wrAddr, dst);
        check("wrData_hold", bus.wrData, exp);
        check("one_pulse", wr_pulses - p0, 1);
        if (stress) begin
            repeat (25) @(negedge clk);
            check("ignored_starts", wr_pulses - p0, 1);
        end
    endtask

    initial begin
        int p0;
        bus.start = 1'b0; bus.op = 2'd0; bus.opA = 16'd0; bus.opB = 16'd0; bus.dstAddr = 4'd0;
        rst = 1'b1;
        #12;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_write", bus.write, 1'b0);
        check("rst_wrAddr", bus.wrAddr, 4'd0);
        check("rst_wrData", bus.wrData, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b00, 16'h1234, 16'h0010, 4'd5,  16'h2340, 1'b0);
        run_op(2'b01, 16'h1234, 16'h0010, 4'd5,  16'h0001, 1'b0);
        run_op(2'b01, 16'hFFFF, 16'hFFFF, 4'd15, 16'hFFFE, 1'b0);
        run_op(2'b00, 16'hFFFF, 16'hFFFF, 4'd15, 16'h0001, 1'b0);
        run_op(2'b10, 16'd100,  16'd7,    4'd3,  16'h000E, 1'b0);
        run_op(2'b11, 16'd100,  16'd7,    4'd3,  16'h0002, 1'b0);
        run_op(2'b10, 16'h8000, 16'hFFFF, 4'd0,  16'h0000, 1'b0);
        run_op(2'b11, 16'h8000, 16'hFFFF, 4'd1,  16'h8000, 1'b0);
        run_op(2'b10, 16'h1234, 16'h0000, 4'd9,  16'hFFFF, 1'b0);
        run_op(2'b11, 16'h1234, 16'h0000, 4'd10, 16'h1234, 1'b0);
        run_op(2'b00, 16'd3,    16'd5,    4'd7,  16'h000F, 1'b1);

        // Back-to-back: start held high, second operands presented after the first is accepted.
        @(negedge clk);
        drive(2'b00, 16'h00FF, 16'h0101, 4'd2);
        sb_q.push_back('{addr: 4'd2, data: 16'hFFFF});
        p0 = wr_pulses;
        @(negedge clk);
        drive(2'b10, 16'd1000, 16'd10, 4'd4);
        sb_q.push_back('{addr: 4'd4, data: 16'd100});
        wait_write(16, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b_gap_busy", bus.busy, 1'b0);
        wait_write(17, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b_pulses", wr_pulses - p0, 2);

        // Asynchronous reset mid-run: result discarded, no strobe.
        @(negedge clk);
        drive(2'b01, 16'hABCD, 16'h1234, 4'd6);
        p0 = wr_pulses;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_write", bus.write, 1'b0);
        check("arst_wrAddr", bus.wrAddr, 4'd0);
        check("arst_wrData", bus.wrData, 16'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("arst_no_write", wr_pulses - p0, 0);
        run_op(2'b10, 16'd9, 16'd2, 4'd8, 16'h0004, 1'b0);

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
